// File: rtl/jb_pkg.sv
// Shared definitions for the jump/branch predict unit: JumpBranch codes,
// Jump_sel encodings, FSM state type and BHT sizing helpers.
package jb_pkg;

   localparam logic [3:0] JB_NONE = 4'b0000;
   localparam logic [3:0] JB_J    = 4'b0001;
   localparam logic [3:0] JB_JR   = 4'b0010;
   localparam logic [3:0] JB_BEQ  = 4'b0011;
   localparam logic [3:0] JB_BNE  = 4'b0100;
   localparam logic [3:0] JB_BLEZ = 4'b0101;
   localparam logic [3:0] JB_BGTZ = 4'b0110;
   localparam logic [3:0] JB_BLTZ = 4'b0111;
   localparam logic [3:0] JB_BGEZ = 4'b1000;

   localparam logic [1:0] JSEL_PC4 = 2'b00;
   localparam logic [1:0] JSEL_BR  = 2'b01;
   localparam logic [1:0] JSEL_J   = 2'b10;
   localparam logic [1:0] JSEL_RS  = 2'b11;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } jb_state_e;

   function automatic int bht_idx_width(input int depth);
      return $clog2(depth);
   endfunction

   function automatic logic jb_is_cond(input logic [3:0] code);
      return (code >= JB_BEQ) && (code <= JB_BGEZ);
   endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of saturating counters with a combinational
// read port and one synchronous write port (init fill or training update).
module bht_table
   import jb_pkg::*;
#(
   parameter int BHT_DEPTH = 64,
   parameter int CTR_WIDTH = 2,
   localparam int IDX_W = bht_idx_width(BHT_DEPTH)
) (
   input  logic                 clk,
   input  logic                 i_init_we,
   input  logic [IDX_W-1:0]     i_init_idx,
   input  logic                 i_train_we,
   input  logic [IDX_W-1:0]     i_train_idx,
   input  logic                 i_train_taken,
   input  logic [IDX_W-1:0]     i_rd_idx,
   output logic [CTR_WIDTH-1:0] o_rd_ctr
);

   localparam logic [CTR_WIDTH-1:0] CTR_MAX     = {CTR_WIDTH{1'b1}};
   localparam logic [CTR_WIDTH-1:0] CTR_WEAK_NT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

   logic [CTR_WIDTH-1:0] r_ctr [BHT_DEPTH];
   logic [CTR_WIDTH-1:0] w_old;
   logic [CTR_WIDTH-1:0] w_next;

   assign w_old = r_ctr[i_train_idx];

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next = w_old;
      if (i_train_taken) begin
         if (w_old != CTR_MAX) w_next = w_old + CTR_WIDTH'(1);
      end else begin
         if (w_old != '0) w_next = w_old - CTR_WIDTH'(1);
      end
   end

   // NOTE: the counter array has no reset term; the INIT sweep fills it, which keeps it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (i_init_we) begin
         r_ctr[i_init_idx] <= CTR_WEAK_NT;
      end else if (i_train_we) begin
         r_ctr[i_train_idx] <= w_next;
      end
   end

   // Read returns the pre-write value when the same entry is trained this cycle.
   assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/jb_predict_unit.sv
// Jump/branch resolution with a BHT predictor and misprediction flag.
// Optional JB_STATS_EN adds branch/mispredict event counters.
module jb_predict_unit
   import jb_pkg::*;
#(
   parameter int PC_WIDTH  = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CTR_WIDTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                ready,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   output logic                pred_taken,
   input  logic                res_valid,
   input  logic [PC_WIDTH-1:0] res_pc,
   input  logic [3:0]          JumpBranch,
   input  logic [31:0]         ALU_out,
   input  logic                ALU_zero,
   input  logic                res_pred_taken,
   output logic [1:0]          Jump_sel,
   output logic                mispredict,
   output logic                jb_illegal
`ifdef JB_STATS_EN
   ,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispredicts
`endif
);

   localparam int IDX_W = bht_idx_width(BHT_DEPTH);

   jb_state_e            r_state;
   jb_state_e            w_state_nxt;
   logic [IDX_W-1:0]     r_init_ptr;
   logic [IDX_W-1:0]     w_init_ptr_nxt;
   logic                 w_init_we;
   logic                 w_ready;
   logic                 w_is_cond;
   logic                 w_taken;
   logic [1:0]           w_jsel;
   logic                 w_active;
   logic                 w_train;
   logic                 w_mispredict;
   logic [CTR_WIDTH-1:0] w_rd_ctr;
   logic                 w_unused_bits;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values; combinational blocks use blocking (=).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_init_ptr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_ptr <= w_init_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_init_ptr_nxt = r_init_ptr;
      w_init_we      = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_init_we      = rst_n;
            w_init_ptr_nxt = r_init_ptr + IDX_W'(1);
            if (r_init_ptr == IDX_W'(BHT_DEPTH - 1)) w_state_nxt = ST_RUN;
         end
         ST_RUN:  w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // Reset low blanks everything immediately, not just from the next edge.
   assign w_ready  = rst_n && (r_state == ST_RUN);
   assign w_active = w_ready && res_valid;

   always_comb begin
      w_taken = 1'b0;
      w_jsel  = JSEL_PC4;
      case (JumpBranch)
         JB_J:    w_jsel  = JSEL_J;
         JB_JR:   w_jsel  = JSEL_RS;
         JB_BEQ:  w_taken = ALU_zero;
         JB_BNE:  w_taken = !ALU_zero;
         JB_BLEZ: w_taken = (ALU_out == 32'd1) || ALU_zero;
         JB_BGTZ: w_taken = (ALU_out != 32'd1) && !ALU_zero;
         JB_BLTZ: w_taken = (ALU_out == 32'd1);
         JB_BGEZ: w_taken = (ALU_out != 32'd1);
         default: w_jsel  = JSEL_PC4;
      endcase
      if (w_taken) w_jsel = JSEL_BR;
   end

   assign w_is_cond    = jb_is_cond(JumpBranch);
   assign w_train      = w_active && w_is_cond;
   assign w_mispredict = w_train && (w_taken != res_pred_taken);

   assign ready      = w_ready;
   assign Jump_sel   = w_active ? w_jsel : JSEL_PC4;
   assign mispredict = w_mispredict;
   assign jb_illegal = w_active && (JumpBranch > JB_BGEZ);
   assign pred_taken = w_ready && w_rd_ctr[CTR_WIDTH-1];

   bht_table #(
      .BHT_DEPTH (BHT_DEPTH),
      .CTR_WIDTH (CTR_WIDTH)
   ) u_bht (
      .clk           (clk),
      .i_init_we     (w_init_we),
      .i_init_idx    (r_init_ptr),
      .i_train_we    (w_train),
      .i_train_idx   (res_pc[IDX_W+1:2]),
      .i_train_taken (w_taken),
      .i_rd_idx      (fetch_pc[IDX_W+1:2]),
      .o_rd_ctr      (w_rd_ctr)
   );

   // Only the word-index bits of the PCs address the table.
   assign w_unused_bits = ^{fetch_pc[PC_WIDTH-1:IDX_W+2], fetch_pc[1:0],
                            res_pc[PC_WIDTH-1:IDX_W+2], res_pc[1:0]};

`ifdef JB_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
      end else if (w_train) begin
         r_stat_branches <= r_stat_branches + 32'd1;
         if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
   end

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_jb_predict_unit.sv
// Directed self-checking bench for jb_predict_unit (default parameters).
module tb_jb_predict_unit;
   import jb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ready;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic        res_valid;
   logic [31:0] res_pc;
   logic [3:0]  JumpBranch;
   logic [31:0] ALU_out;
   logic        ALU_zero;
   logic        res_pred_taken;
   logic [1:0]  Jump_sel;
   logic        mispredict;
   logic        jb_illegal;
`ifdef JB_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int n_vec  = 0;
   int n_miss = 0;
   int cyc;

   always #5 clk = ~clk;

   jb_predict_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ready          (ready),
      .fetch_pc       (fetch_pc),
      .pred_taken     (pred_taken),
      .res_valid      (res_valid),
      .res_pc         (res_pc),
      .JumpBranch     (JumpBranch),
      .ALU_out        (ALU_out),
      .ALU_zero       (ALU_zero),
      .res_pred_taken (res_pred_taken),
      .Jump_sel       (Jump_sel),
      .mispredict     (mispredict),
      .jb_illegal     (jb_illegal)
`ifdef JB_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a resolving instruction; it trains on the next edge.
   task automatic resolve(input logic [3:0] code, input logic [31:0] pc,
                          input logic [31:0] alu, input logic z, input logic pt);
      tick();
      res_valid      = 1'b1;
      JumpBranch     = code;
      res_pc         = pc;
      ALU_out        = alu;
      ALU_zero       = z;
      res_pred_taken = pt;
      #1;
   endtask

   task automatic lookup(input logic [31:0] pc, input logic exp, input string tag);
      tick();
      res_valid = 1'b0;
      fetch_pc  = pc;
      #1;
      check(tag, {31'd0, pred_taken}, {31'd0, exp});
   endtask

   // Counts edges until ready; a taken BEQ is held on the resolve port
   // early in the sweep to confirm outputs are blanked while not ready.
   task automatic wait_init(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
         if (cycles == 10) begin
            #1;
            check("init_jsel_blank", {30'd0, Jump_sel}, 32'd0);
            check("init_misp_blank", {31'd0, mispredict}, 32'd0);
         end
         if (cycles == 11) res_valid = 1'b0;
      end while (!ready && cycles < 200);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; fetch_pc = '0; res_valid = 1'b1; res_pc = '0;
      JumpBranch = JB_J; ALU_out = '0; ALU_zero = 1'b0; res_pred_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_jsel", {30'd0, Jump_sel}, 32'd0);
      check("rst_pred", {31'd0, pred_taken}, 32'd0);

      rst_n = 1'b1; JumpBranch = JB_BEQ; ALU_zero = 1'b1; res_pred_taken = 1'b0;
      wait_init(cyc);
      check("init_cycles", cyc, 32'd64);
`ifdef JB_STATS_EN
      check("stat_br_zero", stat_branches, 32'd0);
      check("stat_mp_zero", stat_mispredicts, 32'd0);
`endif

      lookup(32'h000, 1'b0, "init_pc000");
      lookup(32'h100, 1'b0, "init_pc100");
      lookup(32'h040, 1'b0, "init_pc040");
      lookup(32'h0FC, 1'b0, "init_pc0fc");

      // BEQ taken, predicted not-taken: index 0 goes 01 -> 10.
      resolve(JB_BEQ, 32'h100, 32'd0, 1'b1, 1'b0);
      check("beq_jsel", {30'd0, Jump_sel}, 32'd1);
      check("beq_misp", {31'd0, mispredict}, 32'd1);
      check("beq_illegal", {31'd0, jb_illegal}, 32'd0);
      lookup(32'h100, 1'b1, "beq_trained");
      lookup(32'h000, 1'b1, "beq_alias");

      // Saturation at index 16: five taken -> 11, then walk down to 00.
      resolve(JB_BNE, 32'h040, 32'd0, 1'b0, 1'b0);
      check("bne_misp", {31'd0, mispredict}, 32'd1);
      repeat (4) resolve(JB_BNE, 32'h040, 32'd0, 1'b0, 1'b0);
      lookup(32'h040, 1'b1, "sat_hi");
      resolve(JB_BNE, 32'h040, 32'd0, 1'b1, 1'b1);
      lookup(32'h040, 1'b1, "sat_nt1");
      resolve(JB_BNE, 32'h040, 32'd0, 1'b1, 1'b1);
      resolve(JB_BNE, 32'h040, 32'd0, 1'b1, 1'b1);
      lookup(32'h040, 1'b0, "sat_nt3");
      resolve(JB_BNE, 32'h040, 32'd0, 1'b1, 1'b1);
      lookup(32'h040, 1'b0, "sat_lo_hold");
      resolve(JB_BNE, 32'h040, 32'd0, 1'b0, 1'b0);
      lookup(32'h040, 1'b0, "sat_lo_plus1");

      // Decode sweep.
      resolve(JB_J, 32'h080, 32'd0, 1'b0, 1'b1);
      check("j_jsel", {30'd0, Jump_sel}, 32'd2);
      check("j_nomisp", {31'd0, mispredict}, 32'd0);
      resolve(JB_JR, 32'h080, 32'd0, 1'b0, 1'b0);
      check("jr_jsel", {30'd0, Jump_sel}, 32'd3);
      resolve(JB_BLEZ, 32'h084, 32'd1, 1'b0, 1'b0);
      check("blez_lt", {30'd0, Jump_sel}, 32'd1);
      resolve(JB_BGTZ, 32'h088, 32'd0, 1'b1, 1'b0);
      check("bgtz_zero", {30'd0, Jump_sel}, 32'd0);
      resolve(JB_BGEZ, 32'h08C, 32'd0, 1'b0, 1'b0);
      check("bgez_ge", {30'd0, Jump_sel}, 32'd1);
      resolve(4'b1010, 32'h080, 32'd0, 1'b0, 1'b1);
      check("ill_jsel", {30'd0, Jump_sel}, 32'd0);
      check("ill_flag", {31'd0, jb_illegal}, 32'd1);
      check("ill_nomisp", {31'd0, mispredict}, 32'd0);
      resolve(JB_BLTZ, 32'h3C0, 32'd2, 1'b0, 1'b0);
      check("bltz_two", {30'd0, Jump_sel}, 32'd0);
      resolve(JB_BLTZ, 32'h3C0, 32'd1, 1'b0, 1'b1);
      check("bltz_lt", {30'd0, Jump_sel}, 32'd1);
      check("bltz_okpred", {31'd0, mispredict}, 32'd0);
      resolve(JB_BGEZ, 32'h3C0, 32'd1, 1'b0, 1'b0);
      check("bgez_lt", {30'd0, Jump_sel}, 32'd0);
      resolve(JB_BGTZ, 32'h3C0, 32'd0, 1'b0, 1'b1);
      check("bgtz_gt", {30'd0, Jump_sel}, 32'd1);
      resolve(JB_BLEZ, 32'h3C0, 32'd0, 1'b0, 1'b0);
      check("blez_gt", {30'd0, Jump_sel}, 32'd0);
      resolve(JB_BEQ, 32'h3C0, 32'd0, 1'b0, 1'b0);
      check("beq_nt", {30'd0, Jump_sel}, 32'd0);
      resolve(JB_J, 32'h080, 32'd0, 1'b0, 1'b0);
      res_valid = 1'b0;
      #1;
      check("j_invalid", {30'd0, Jump_sel}, 32'd0);
      resolve(4'b1111, 32'h080, 32'd0, 1'b0, 1'b0);
      res_valid = 1'b0;
      #1;
      check("ill_invalid", {31'd0, jb_illegal}, 32'd0);
      lookup(32'h080, 1'b0, "jmp_no_train");
      lookup(32'h084, 1'b1, "blez_trained");
      lookup(32'h088, 1'b0, "bgtz_trained");
      lookup(32'h08C, 1'b1, "bgez_trained");

      // Same-cycle hazard on index 0: drop it to 01, then train while looking up.
      resolve(JB_BNE, 32'h000, 32'd0, 1'b1, 1'b1);
      resolve(JB_BEQ, 32'h200, 32'd0, 1'b1, 1'b0);
      fetch_pc = 32'h200;
      #1;
      check("hazard_old", {31'd0, pred_taken}, 32'd0);
      lookup(32'h200, 1'b1, "hazard_new");

      // Mid-RUN reset and re-init.
      tick();
      rst_n = 1'b0;
      res_valid = 1'b0;
      #1;
      check("rerst_ready", {31'd0, ready}, 32'd0);
      check("rerst_pred", {31'd0, pred_taken}, 32'd0);
      tick();
      rst_n = 1'b1; res_valid = 1'b1; JumpBranch = JB_BEQ; ALU_zero = 1'b1; res_pred_taken = 1'b0;
      wait_init(cyc);
      check("reinit_cycles", cyc, 32'd64);
`ifdef JB_STATS_EN
      check("stat_br_rezero", stat_branches, 32'd0);
      check("stat_mp_rezero", stat_mispredicts, 32'd0);
`endif
      lookup(32'h200, 1'b0, "reinit_idx0");
      resolve(JB_BNE, 32'h040, 32'd0, 1'b0, 1'b0);
      resolve(JB_BEQ, 32'h088, 32'd0, 1'b1, 1'b1);
      lookup(32'h040, 1'b1, "reinit_idx16");
      lookup(32'h088, 1'b1, "reinit_idx34");
`ifdef JB_STATS_EN
      check("stat_br_count", stat_branches, 32'd2);
      check("stat_mp_count", stat_mispredicts, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
